// File: rtl/ama_riscv_spec_ctrl.sv
// Speculation controller: tracks one in-flight conditional branch, reports resolve/outcome for predictor training,
// and redirects fetch on a mispredict. Optional SPEC_STATS_EN adds saturating resolve/mispredict counters.
module ama_riscv_spec_ctrl #(
    parameter int unsigned ARCH_W = 32,
    parameter int unsigned STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_stall,
    input  logic              dec_branch,
    input  logic [ARCH_W-1:0] dec_pc,
    input  logic [ARCH_W-1:0] dec_br_tgt,
    input  logic              bp_pred,
    input  logic              exe_br_valid,
    input  logic              exe_br_taken,
    output logic              spec_enter,
    output logic              spec_resolve,
    output logic              br_res,
    output logic [ARCH_W-1:0] pc_exe,
    output logic              dec_hold,
    output logic              flush,
    output logic              redirect,
    output logic [ARCH_W-1:0] redirect_pc,
    output logic              spec_err,
    output logic [STAT_W-1:0] stat_br_cnt,
    output logic [STAT_W-1:0] stat_mp_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SPEC    = 2'd1;
    localparam logic [1:0] RECOVER = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              pred_q;
    logic [ARCH_W-1:0] tgt_q;
    logic [ARCH_W-1:0] fall_q;
    logic              mispredict;

    assign spec_resolve = (state == SPEC) & exe_br_valid;
    assign br_res       = exe_br_taken;
    assign mispredict   = spec_resolve & (exe_br_taken != pred_q);
    assign spec_enter   = dec_branch & ~pipe_stall & ~dec_hold;

    // Decode hold: wrong-path decode on mispredict, recovery bubble, or a second branch while one is in flight
    always_comb begin
        dec_hold = 1'b0;
        case (state)
            SPEC: begin
                if (exe_br_valid) dec_hold = mispredict;
                else              dec_hold = dec_branch;
            end
            RECOVER: dec_hold = 1'b1;
            default: dec_hold = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (spec_enter) state_nxt = SPEC;
            end
            SPEC: begin
                if (exe_br_valid) begin
                    if (mispredict)      state_nxt = RECOVER;
                    else if (spec_enter) state_nxt = SPEC;
                    else                 state_nxt = IDLE;
                end
            end
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Window capture; spec_enter is already gated by dec_hold so it covers back-to-back entry too
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_exe <= '0;
            pred_q <= 1'b0;
            tgt_q  <= '0;
            fall_q <= '0;
        end else if (spec_enter) begin
            pc_exe <= dec_pc;
            pred_q <= bp_pred;
            tgt_q  <= dec_br_tgt;
            fall_q <= dec_pc + ARCH_W'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush       <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            spec_err    <= 1'b0;
        end else begin
            flush    <= mispredict;
            redirect <= mispredict;
            if (mispredict) redirect_pc <= exe_br_taken ? tgt_q : fall_q;
            if ((state == IDLE) && exe_br_valid) spec_err <= 1'b1;
        end
    end

`ifdef SPEC_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_cnt <= '0;
            stat_mp_cnt <= '0;
        end else begin
            if (spec_resolve && (stat_br_cnt != STAT_MAX)) stat_br_cnt <= stat_br_cnt + STAT_W'(1);
            if (mispredict && (stat_mp_cnt != STAT_MAX))   stat_mp_cnt <= stat_mp_cnt + STAT_W'(1);
        end
    end
`else
    assign stat_br_cnt = '0;
    assign stat_mp_cnt = '0;
`endif

endmodule

// File: tb/tb_ama_riscv_spec_ctrl.sv
// Directed self-checking bench for ama_riscv_spec_ctrl; inputs change 1ns after posedge, outputs sampled 1ns later.
module tb_ama_riscv_spec_ctrl;

    localparam int unsigned ARCH_W = 32;
    localparam int unsigned STAT_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              pipe_stall;
    logic              dec_branch;
    logic [ARCH_W-1:0] dec_pc;
    logic [ARCH_W-1:0] dec_br_tgt;
    logic              bp_pred;
    logic              exe_br_valid;
    logic              exe_br_taken;
    logic              spec_enter;
    logic              spec_resolve;
    logic              br_res;
    logic [ARCH_W-1:0] pc_exe;
    logic              dec_hold;
    logic              flush;
    logic              redirect;
    logic [ARCH_W-1:0] redirect_pc;
    logic              spec_err;
    logic [STAT_W-1:0] stat_br_cnt;
    logic [STAT_W-1:0] stat_mp_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ama_riscv_spec_ctrl #(.ARCH_W(ARCH_W), .STAT_W(STAT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_stall   (pipe_stall),
        .dec_branch   (dec_branch),
        .dec_pc       (dec_pc),
        .dec_br_tgt   (dec_br_tgt),
        .bp_pred      (bp_pred),
        .exe_br_valid (exe_br_valid),
        .exe_br_taken (exe_br_taken),
        .spec_enter   (spec_enter),
        .spec_resolve (spec_resolve),
        .br_res       (br_res),
        .pc_exe       (pc_exe),
        .dec_hold     (dec_hold),
        .flush        (flush),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .spec_err     (spec_err),
        .stat_br_cnt  (stat_br_cnt),
        .stat_mp_cnt  (stat_mp_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        dec_branch   = 1'b0;
        exe_br_valid = 1'b0;
        exe_br_taken = 1'b0;
        pipe_stall   = 1'b0;
    endtask

    task automatic drive_br(input logic [ARCH_W-1:0] pc, input logic [ARCH_W-1:0] tgt, input logic pred);
        dec_branch = 1'b1;
        dec_pc     = pc;
        dec_br_tgt = tgt;
        bp_pred    = pred;
    endtask

    // Enter a branch from IDLE, then resolve it after one idle cycle; leaves inputs idle after the resolve edge
    task automatic run_branch(input string tag, input logic [ARCH_W-1:0] pc, input logic [ARCH_W-1:0] tgt,
                              input logic pred, input logic taken);
        drive_br(pc, tgt, pred);
        #1;
        check({tag, "_enter"}, 64'(spec_enter), 64'd1);
        tick();
        idle_in();
        #1;
        check({tag, "_pc_exe"}, 64'(pc_exe), 64'(pc));
        tick();
        exe_br_valid = 1'b1;
        exe_br_taken = taken;
        #1;
        check({tag, "_resolve"}, 64'(spec_resolve), 64'd1);
        check({tag, "_br_res"}, 64'(br_res), 64'(taken));
        tick();
        idle_in();
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        dec_pc     = '0;
        dec_br_tgt = '0;
        bp_pred    = 1'b0;
        #2;
        check("rst_pc_exe", 64'(pc_exe), 64'd0);
        check("rst_flush", 64'(flush), 64'd0);
        check("rst_redirect", 64'(redirect), 64'd0);
        check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        check("rst_spec_err", 64'(spec_err), 64'd0);
        check("rst_stat_br", 64'(stat_br_cnt), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // correct not-taken
        run_branch("nt_ok", 32'h100, 32'h180, 1'b0, 1'b0);
        #1;
        check("nt_ok_flush", 64'(flush), 64'd0);
        check("nt_ok_redirect", 64'(redirect), 64'd0);
        dec_branch = 1'b1;
        dec_pc     = 32'h500;
        pipe_stall = 1'b1;
        #1;
        check("nt_ok_idle_stall_enter", 64'(spec_enter), 64'd0);
        pipe_stall = 1'b0;
        #1;
        check("nt_ok_idle_enter", 64'(spec_enter), 64'd1);
        dec_branch = 1'b0;
        tick();

        // mispredict taken, with a wrong-path branch in decode during the resolve
        drive_br(32'h100, 32'h180, 1'b0);
        tick();
        idle_in();
        tick();
        exe_br_valid = 1'b1;
        exe_br_taken = 1'b1;
        dec_branch   = 1'b1;
        dec_pc       = 32'h104;
        #1;
        check("mp_t_resolve", 64'(spec_resolve), 64'd1);
        check("mp_t_hold", 64'(dec_hold), 64'd1);
        check("mp_t_no_enter", 64'(spec_enter), 64'd0);
        tick();
        exe_br_valid = 1'b0;
        #1;
        check("mp_t_flush", 64'(flush), 64'd1);
        check("mp_t_redirect", 64'(redirect), 64'd1);
        check("mp_t_redirect_pc", 64'(redirect_pc), 64'h180);
        check("mp_t_recover_hold", 64'(dec_hold), 64'd1);
        check("mp_t_recover_enter", 64'(spec_enter), 64'd0);
        tick();
        #1;
        check("mp_t_flush_pulse", 64'(flush), 64'd0);
        check("mp_t_redirect_pulse", 64'(redirect), 64'd0);
        check("mp_t_idle_hold", 64'(dec_hold), 64'd0);
        check("mp_t_pc_exe_kept", 64'(pc_exe), 64'h100);
        dec_branch = 1'b0;

        // mispredict not-taken
        run_branch("mp_nt", 32'h200, 32'h280, 1'b1, 1'b0);
        #1;
        check("mp_nt_redirect_pc", 64'(redirect_pc), 64'h204);
        tick();

        // back-to-back: correct resolve of 0x100 while 0x104 enters
        drive_br(32'h100, 32'h180, 1'b0);
        tick();
        idle_in();
        tick();
        exe_br_valid = 1'b1;
        exe_br_taken = 1'b0;
        drive_br(32'h104, 32'h300, 1'b1);
        #1;
        check("b2b_resolve", 64'(spec_resolve), 64'd1);
        check("b2b_enter", 64'(spec_enter), 64'd1);
        check("b2b_hold", 64'(dec_hold), 64'd0);
        tick();
        idle_in();
        #1;
        check("b2b_pc_exe", 64'(pc_exe), 64'h104);
        check("b2b_flush", 64'(flush), 64'd0);
        exe_br_valid = 1'b1;
        exe_br_taken = 1'b1;
        #1;
        check("b2b_resolve2", 64'(spec_resolve), 64'd1);
        tick();
        idle_in();
        #1;
        check("b2b_no_flush2", 64'(flush), 64'd0);

        // hold: second branch while one is in flight
        drive_br(32'h400, 32'h480, 1'b0);
        tick();
        drive_br(32'h404, 32'h500, 1'b0);
        #1;
        check("hold_dec_hold", 64'(dec_hold), 64'd1);
        check("hold_no_enter", 64'(spec_enter), 64'd0);
        tick();
        idle_in();
        #1;
        check("hold_pc_exe", 64'(pc_exe), 64'h400);
        exe_br_valid = 1'b1;
        tick();
        idle_in();

        // protocol error: resolve in IDLE
        check("err_before", 64'(spec_err), 64'd0);
        exe_br_valid = 1'b1;
        #1;
        check("err_no_resolve", 64'(spec_resolve), 64'd0);
        tick();
        idle_in();
        tick();
        #1;
        check("err_sticky", 64'(spec_err), 64'd1);

        // async reset mid-window abandons it
        drive_br(32'h600, 32'h680, 1'b0);
        tick();
        idle_in();
        #2;
        rst          = 1'b1;
        exe_br_valid = 1'b1;
        #1;
        check("arst_pc_exe", 64'(pc_exe), 64'd0);
        check("arst_spec_err", 64'(spec_err), 64'd0);
        check("arst_redirect_pc", 64'(redirect_pc), 64'd0);
        check("arst_no_resolve", 64'(spec_resolve), 64'd0);
        exe_br_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // PC wrap on fall-through
        run_branch("wrap", 32'hFFFF_FFFC, 32'h1000, 1'b1, 1'b0);
        #1;
        check("wrap_redirect_pc", 64'(redirect_pc), 64'h0);
        tick();
        tick();

        run_branch("st1", 32'h700, 32'h780, 1'b0, 1'b0);
        run_branch("st2", 32'h710, 32'h790, 1'b1, 1'b1);
        #1;
`ifdef SPEC_STATS_EN
        check("stat_br_cnt", 64'(stat_br_cnt), 64'd3);
        check("stat_mp_cnt", 64'(stat_mp_cnt), 64'd1);
`else
        check("stat_br_cnt_off", 64'(stat_br_cnt), 64'd0);
        check("stat_mp_cnt_off", 64'(stat_mp_cnt), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ama_riscv_spec_ctrl.md
Name: ama_riscv_spec_ctrl

Overview:
- Speculation controller that produces the branch-resolution side of the predictor interface.
- Opens a speculative window when a conditional branch leaves decode, records the predicted direction and both candidate PCs, and closes the window when execute resolves the branch.
- Emits the enter/resolve/outcome/PC signals that drive predictor training.
- Issues a fetch redirect and pipeline flush on a mispredict.
- Sits between decode/execute control and fetch, alongside the branch predictor.

Parameters:
- ARCH_W, 32, PC/target width in bits.
- STAT_W, 32, width of each statistics counter (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- pipe_stall  in  1  pipeline frozen; no decode advance this cycle
- dec_branch  in  1  conditional branch valid in decode
- dec_pc  in  ARCH_W  PC of the decode instruction
- dec_br_tgt  in  ARCH_W  taken-target computed in decode
- bp_pred  in  1  predictor direction for the decode branch (1 = B_T)
- exe_br_valid  in  1  branch outcome valid in execute
- exe_br_taken  in  1  actual branch outcome
- spec_enter  out  1  speculative window opened (feeds spec.enter)
- spec_resolve  out  1  branch resolved this cycle (feeds spec.resolve)
- br_res  out  1  resolved outcome (feeds br_res)
- pc_exe  out  ARCH_W  PC of the in-flight branch (feeds pc_exe)
- dec_hold  out  1  stall decode; second branch cannot enter
- flush  out  1  kill wrong-path instructions in IF/ID
- redirect  out  1  fetch redirect valid
- redirect_pc  out  ARCH_W  correct next PC
- spec_err  out  1  sticky protocol error
- stat_br_cnt  out  STAT_W  resolved branch count (optional)
- stat_mp_cnt  out  STAT_W  mispredict count (optional)

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - pc_exe, saved target, saved fall-through, saved prediction, redirect_pc, stats all cleared to 0.
  - flush, redirect, spec_err = 0.
  - Reset mid-window abandons the window; no resolve is emitted.
- Combinational outputs:
  - spec_enter = dec_branch & ~pipe_stall & ~dec_hold.
  - spec_resolve = (state==SPEC) & exe_br_valid.
  - br_res = exe_br_taken.
- Registered state: pc_exe, pred_q, tgt_q, fall_q (= dec_pc + 4, wraps modulo 2^ARCH_W).
- FSM states IDLE, SPEC, RECOVER:
  - IDLE:
    - spec_enter captures dec_pc -> pc_exe, bp_pred -> pred_q, dec_br_tgt -> tgt_q, dec_pc + 4 -> fall_q; next state SPEC.
    - exe_br_valid in IDLE sets spec_err (sticky until reset) and is otherwise ignored.
  - SPEC, resolve without mispredict (exe_br_taken == pred_q):
    - If spec_enter in the same cycle, capture the new branch and stay in SPEC (back-to-back, zero bubble).
    - Otherwise go to IDLE.
  - SPEC, resolve with mispredict (exe_br_taken != pred_q):
    - Next cycle: flush = 1, redirect = 1, redirect_pc = exe_br_taken ? tgt_q : fall_q. Both are single-cycle pulses.
    - State goes to RECOVER. Any spec_enter in the mispredict cycle is suppressed: dec_hold = 1, because that decode instruction is wrong-path.
  - SPEC without resolve: hold. dec_hold = dec_branch.
  - RECOVER: one cycle. dec_hold = 1. Next state IDLE.
- Latency:
  - Resolve pulse is in the same cycle as exe_br_valid.
  - Redirect/flush follow exactly 1 cycle after the mispredicting resolve.
- Stalls:
  - pipe_stall blocks enter only.
  - Resolve does not depend on pipe_stall; execute owns exe_br_valid.
- At most one outstanding speculative branch at any time.

Optional Feature:
- Macro: SPEC_STATS_EN.
- Defined:
  - stat_br_cnt increments on every spec_resolve.
  - stat_mp_cnt increments on every mispredicting resolve.
  - Both saturate at 2^STAT_W-1 and clear on reset.
- Undefined: counters are not instantiated; both outputs are tied to 0.

Test Plan:
- Correct not-taken:
  - Stimulus: dec_branch=1, dec_pc=0x100, bp_pred=0, tgt=0x180; two cycles later exe_br_valid=1, taken=0.
  - Response: spec_enter pulse at cycle 0, pc_exe=0x100, spec_resolve with br_res=0, no flush/redirect, state IDLE.
- Mispredict taken:
  - Stimulus: same branch but taken=1.
  - Response: the cycle after resolve has flush=1, redirect=1, redirect_pc=0x180. Next cycle has dec_hold=1 (RECOVER), then IDLE.
- Mispredict not-taken:
  - Stimulus: bp_pred=1, dec_pc=0x200, taken=0.
  - Response: redirect_pc=0x204.
- Back-to-back:
  - Stimulus: correct resolve of 0x100 in the same cycle as dec_branch at 0x104.
  - Response: spec_resolve and spec_enter both 1, pc_exe=0x104 next cycle, no hold.
- Hold and stall:
  - Stimulus: in SPEC, dec_branch=1 without resolve; also pipe_stall=1 in IDLE with dec_branch=1.
  - Response: first case dec_hold=1, no enter. Second case spec_enter=0.
- Error, wrap, reset, stats:
  - Error: exe_br_valid in IDLE -> spec_err=1, held until rst.
  - Wrap: dec_pc=0xFFFFFFFC mispredicted not-taken -> redirect_pc=0x0.
  - Reset: async rst during SPEC -> all outputs 0 immediately.
  - Stats: with SPEC_STATS_EN, 3 resolves with 1 mispredict -> stat_br_cnt=3, stat_mp_cnt=1.
